data_mem_ctrl_m1: RTL and testbench
===================================

# data_mem_ctrl_m1

Responder end of the M1 core's memory controller interface: accepts load, store and fence requests issued by the LSU, executes them in order against an on-chip word-organised data RAM, and returns load results tagged with their writeback register. Sits between the core's `mem_*` outputs and inputs, in the same clock domain as the core. Provides the `mem_available` backpressure and `mem_idle` drain status the LSU relies on for fences.

## Interface

Parameters:
- `ADDR_W`, 12: implemented RAM address bits; RAM holds 2**ADDR_W 16-bit words; address bits [14:ADDR_W] ignored (aliasing).
- `QDEPTH`, 4: request queue entries; power of two, ≥2.

Ports (clock and reset: one clock; reset is synchronous and active-low):
- `clk` in 1: core clock.
- `sync_rst_n` in 1: synchronous active-low reset.
- `clk_en` in 1: global enable; low freezes all state.
- `mem_address_out` in 15: word address.
- `mem_mask_out` in 2: byte lanes; bit0 = [7:0], bit1 = [15:8].
- `mem_read_fnc_type` in 2: read type (0 word, 1 signed byte, 2 unsigned byte, 3 word) or fence type.
- `mem_data_out` in 16: store data, lane-aligned.
- `mem_mode` in 2: 0 read, 1 write, 2/3 fence.
- `mem_enable` in 1: request valid.
- `mem_wb_dest` in 4: load destination register tag.
- `mem_input_ready` in 1: core accepts the presented load result.
- `mem_data_in` out 16: load result.
- `mem_wb_dest_in` out 4: tag of load result.
- `mem_read_ack` out 1: load result valid.
- `mem_available` out 1: request will be accepted this cycle.
- `mem_idle` out 1: no queued, executing or unreturned work.

## Operation

- Accept: `clk_en && mem_enable && mem_available` at an edge pushes {mode, addr, mask, type, data, tag} into the queue.
- `mem_available` = !queue_full && !fence_pending (combinational from state).
- Head executes when queue non-empty and, for reads, the response slot is free (or being freed this cycle):
  - Write: RAM lanes with mask bit set take `mem_data_out` lanes; mask 0 = no-op; pops at that edge; no ack.
  - Read: synchronous RAM read; result into response register with tag; pops.
  - Byte read: lane = mask bit1 ? high : low (bit1 wins if both set); type 1 sign-extends, type 2 zero-extends. Types 0/3 return full word, mask ignored.
  - Fence (mode 2 or 3, type ignored): sets fence_pending at acceptance; at head, pops only when response slot empty; fence_pending clears at that pop. No ack.
- Response: `mem_read_ack` high while slot valid; data/tag stable until `clk_en && mem_input_ready`, which frees the slot.
- `mem_idle` = queue empty && response slot empty && !fence_pending.
- Strict program order; a read after a write to the same address returns new data (write commits at head before later reads execute).

## Timing

- Reset (`!sync_rst_n` at edge): queue, pointers, count, fence_pending, response slot cleared. Outputs after reset: `mem_read_ack`=0, `mem_data_in`=0, `mem_wb_dest_in`=0, `mem_available`=1, `mem_idle`=1. RAM contents not cleared. Reset mid-operation discards all queued and unreturned requests.
- Load latency: accepted at edge N, executes at edge N+1, `mem_read_ack` high during cycle after N+1 (2 cycles), given empty queue and free slot.
- Throughput: one request per cycle accepted and one executed per cycle.
- Full: at QDEPTH entries `mem_available`=0; push blocked; a pop that cycle does not enable a push the same cycle.
- Pointers wrap modulo QDEPTH; count distinguishes full/empty.
- Simultaneous push and pop: count unchanged.
- Slot held (ready low) with read at head: head stalls; writes behind it also stall (in order).
- `clk_en` low: no accept, no execute, no release, outputs hold.

## Configuration

- `DMEM_RESP_SKID_EN`: defined → response path is a 2-entry FIFO; reads execute while one result awaits `mem_input_ready`; head stalls only when both full; fence waits for both empty. Undefined → single response register as above.

## Test plan

- Reset, then write 0xBEEF to 0x0010 mask 2'b11, read word from 0x0010 tag 5 → ack exactly 2 cycles after read acceptance, data 0xBEEF, tag 5.
- Write 0x80 in low lane, read type 1 mask 2'b01 → 0xFF80; type 2 → 0x0080; type 1 mask 2'b10 on 0x7F00 → 0x007F.
- Hold `mem_input_ready`=0, issue QDEPTH+2 reads → `mem_available` falls after QDEPTH+1 accepts (slot + queue); release → results in order, tags intact.
- Issue write, read, fence, then attempt request → `mem_available`=0 until fence pops after ack consumed; `mem_idle`=1 one cycle later.
- Address 0x1010 with ADDR_W=12 → aliases 0x0010.
- Deassert `sync_rst_n` with 3 queued reads → no acks after reset, `mem_idle`=1, RAM data retained.

Source files
------------

// File: rtl/data_mem_ctrl_m1.sv
// data_mem_ctrl_m1: responder side of the M1 memory controller interface.
// Queues LSU load/store/fence requests, executes them in program order against
// a 16-bit word RAM and returns tagged load results.
//
// Ports:
//   clk, sync_rst_n       clock, synchronous active-low reset
//   clk_en                global enable, low freezes all state
//   mem_address_out       word address (bits above ADDR_W alias)
//   mem_mask_out          byte lanes (bit0 = [7:0], bit1 = [15:8])
//   mem_read_fnc_type     0/3 word, 1 signed byte, 2 unsigned byte
//   mem_data_out          lane-aligned store data
//   mem_mode              0 read, 1 write, 2/3 fence
//   mem_enable            request valid
//   mem_wb_dest           load destination tag
//   mem_input_ready       core consumes the presented load result
//   mem_data_in           load result
//   mem_wb_dest_in        load result tag
//   mem_read_ack          load result valid
//   mem_available         request accepted this cycle if enabled
//   mem_idle              no queued, executing or unreturned work
//
// Build option: DMEM_RESP_SKID_EN turns the response register into a
// 2-entry FIFO so reads keep executing while one result is unconsumed.
module data_mem_ctrl_m1 #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        clk_en,
  input  logic [14:0] mem_address_out,
  input  logic [1:0]  mem_mask_out,
  input  logic [1:0]  mem_read_fnc_type,
  input  logic [15:0] mem_data_out,
  input  logic [1:0]  mem_mode,
  input  logic        mem_enable,
  input  logic [3:0]  mem_wb_dest,
  input  logic        mem_input_ready,
  output logic [15:0] mem_data_in,
  output logic [3:0]  mem_wb_dest_in,
  output logic        mem_read_ack,
  output logic        mem_available,
  output logic        mem_idle
);

  localparam int unsigned PTR_W     = $clog2(QDEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_WORDS = 2 ** ADDR_W;

  typedef struct packed {
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        mask;
    logic [1:0]        rtype;
    logic [15:0]       data;
    logic [3:0]        tag;
  } req_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  tag;
  } resp_t;

  // Request queue and RAM storage
  req_t        queue_q [QDEPTH];
  logic [15:0] ram_q   [RAM_WORDS];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fence_pend_q, fence_pend_d;

  // Response slot 0 drives the outputs; slot 1 only fills in skid builds
  resp_t resp0_q, resp0_d;
  resp_t resp1_q, resp1_d;
  logic  resp0_vld_q, resp0_vld_d;
  logic  resp1_vld_q, resp1_vld_d;

  req_t        new_req_c;
  req_t        head_c;
  logic        q_empty_c;
  logic        q_full_c;
  logic        push_c;
  logic        pop_c;
  logic        resp_pop_c;
  logic        resp_room_c;
  logic        head_rd_c;
  logic        head_wr_c;
  logic        head_fence_c;
  logic        ram_we_c;
  logic [15:0] rd_word_c;
  logic [7:0]  rd_byte_c;
  logic [15:0] rd_data_c;
  logic        unused_addr_c;

  // Upper address bits alias onto the implemented RAM
  assign unused_addr_c = ^mem_address_out[14:ADDR_W];

  assign new_req_c = '{mode:  mem_mode,
                       addr:  mem_address_out[ADDR_W-1:0],
                       mask:  mem_mask_out,
                       rtype: mem_read_fnc_type,
                       data:  mem_data_out,
                       tag:   mem_wb_dest};

  assign head_c       = queue_q[rd_ptr_q];
  assign q_empty_c    = (count_q == '0);
  assign q_full_c     = (count_q == CNT_W'(QDEPTH));
  assign head_fence_c = head_c.mode[1];
  assign head_wr_c    = (head_c.mode == 2'd1);
  assign head_rd_c    = (head_c.mode == 2'd0);

  assign mem_available = !q_full_c && !fence_pend_q;
  assign mem_idle      = q_empty_c && !resp0_vld_q && !fence_pend_q;

  assign push_c     = clk_en && mem_enable && mem_available;
  assign resp_pop_c = clk_en && resp0_vld_q && mem_input_ready;

  // A read may execute when a response entry is free or is being freed now
`ifdef DMEM_RESP_SKID_EN
  assign resp_room_c = !resp1_vld_q || resp_pop_c;
`else
  assign resp_room_c = !resp0_vld_q || resp_pop_c;
`endif

  // Fences wait for every response entry to drain (slot 1 implies slot 0)
  assign pop_c = clk_en && !q_empty_c &&
                 (head_wr_c ||
                  (head_rd_c && resp_room_c) ||
                  (head_fence_c && !resp0_vld_q));

  assign ram_we_c = pop_c && head_wr_c;

  // Load result formatting: high lane wins when both mask bits are set
  always_comb begin
    rd_word_c = ram_q[head_c.addr];
    rd_byte_c = head_c.mask[1] ? rd_word_c[15:8] : rd_word_c[7:0];
    rd_data_c = rd_word_c;
    case (head_c.rtype)
      2'd1:    rd_data_c = {{8{rd_byte_c[7]}}, rd_byte_c};
      2'd2:    rd_data_c = {8'h00, rd_byte_c};
      default: rd_data_c = rd_word_c;
    endcase
  end

  // Queue pointers, occupancy and fence tracking
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fence_pend_d = fence_pend_q;
    count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (mem_mode[1]) begin
        fence_pend_d = 1'b1;
      end
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head_fence_c) begin
        fence_pend_d = 1'b0;
      end
    end
  end

  // Response slots: pop shifts slot 1 forward, push fills the first free slot
  always_comb begin
    resp0_d     = resp0_q;
    resp1_d     = resp1_q;
    resp0_vld_d = resp0_vld_q;
    resp1_vld_d = resp1_vld_q;
    if (resp_pop_c) begin
      resp0_d     = resp1_q;
      resp0_vld_d = resp1_vld_q;
      resp1_vld_d = 1'b0;
    end
    if (pop_c && head_rd_c) begin
      if (!resp0_vld_d) begin
        resp0_d     = '{data: rd_data_c, tag: head_c.tag};
        resp0_vld_d = 1'b1;
      end else begin
        resp1_d     = '{data: rd_data_c, tag: head_c.tag};
        resp1_vld_d = 1'b1;
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fence_pend_q <= 1'b0;
      resp0_q      <= '0;
      resp1_q      <= '0;
      resp0_vld_q  <= 1'b0;
      resp1_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fence_pend_q <= fence_pend_d;
      resp0_q      <= resp0_d;
      resp1_q      <= resp1_d;
      resp0_vld_q  <= resp0_vld_d;
      resp1_vld_q  <= resp1_vld_d;
    end
  end

  // Queue payload storage; stale entries are harmless once pointers reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      queue_q[wr_ptr_q] <= new_req_c;
    end
  end

  // Data RAM, byte-lane writes, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      if (head_c.mask[0]) begin
        ram_q[head_c.addr][7:0] <= head_c.data[7:0];
      end
      if (head_c.mask[1]) begin
        ram_q[head_c.addr][15:8] <= head_c.data[15:8];
      end
    end
  end

  assign mem_read_ack   = resp0_vld_q;
  assign mem_data_in    = resp0_q.data;
  assign mem_wb_dest_in = resp0_q.tag;

endmodule

// File: tb/tb_data_mem_ctrl_m1.sv
// Directed testbench for data_mem_ctrl_m1 (default build, QDEPTH=4, ADDR_W=12).
module tb_data_mem_ctrl_m1;

  localparam int unsigned QDEPTH = 4;

  logic        clk = 1'b0;
  logic        sync_rst_n;
  logic        clk_en;
  logic [14:0] mem_address_out;
  logic [1:0]  mem_mask_out;
  logic [1:0]  mem_read_fnc_type;
  logic [15:0] mem_data_out;
  logic [1:0]  mem_mode;
  logic        mem_enable;
  logic [3:0]  mem_wb_dest;
  logic        mem_input_ready;
  logic [15:0] mem_data_in;
  logic [3:0]  mem_wb_dest_in;
  logic        mem_read_ack;
  logic        mem_available;
  logic        mem_idle;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_ctrl_m1 #(.ADDR_W(12), .QDEPTH(QDEPTH)) dut (
    .clk               (clk),
    .sync_rst_n        (sync_rst_n),
    .clk_en            (clk_en),
    .mem_address_out   (mem_address_out),
    .mem_mask_out      (mem_mask_out),
    .mem_read_fnc_type (mem_read_fnc_type),
    .mem_data_out      (mem_data_out),
    .mem_mode          (mem_mode),
    .mem_enable        (mem_enable),
    .mem_wb_dest       (mem_wb_dest),
    .mem_input_ready   (mem_input_ready),
    .mem_data_in       (mem_data_in),
    .mem_wb_dest_in    (mem_wb_dest_in),
    .mem_read_ack      (mem_read_ack),
    .mem_available     (mem_available),
    .mem_idle          (mem_idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mode, input logic [14:0] addr, input logic [1:0] mask,
                       input logic [1:0] typ, input logic [15:0] data, input logic [3:0] tag);
    mem_mode          = mode;
    mem_address_out   = addr;
    mem_mask_out      = mask;
    mem_read_fnc_type = typ;
    mem_data_out      = data;
    mem_wb_dest       = tag;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [14:0] addr, input logic [1:0] mask,
                       input logic [1:0] typ, input logic [15:0] data, input logic [3:0] tag);
    drive(mode, addr, mask, typ, data, tag);
    mem_enable = 1'b1;
    tick();
    mem_enable = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int i;
    i = 0;
    while (!mem_read_ack && i < 10) begin
      tick();
      i++;
    end
    check_eq({tag, "_ack"}, 32'(mem_read_ack), 32'd1);
  endtask

  // Issue a read with mem_input_ready high, check the result, consume it
  task automatic read_expect(input string tag, input logic [14:0] addr, input logic [1:0] mask,
                             input logic [1:0] typ, input logic [3:0] rtag, input logic [15:0] exp);
    issue(2'd0, addr, mask, typ, 16'h0000, rtag);
    wait_ack(tag);
    check_eq({tag, "_data"}, 32'(mem_data_in), 32'(exp));
    check_eq({tag, "_tag"}, 32'(mem_wb_dest_in), 32'(rtag));
    tick();
  endtask

  initial begin
    int acc;
    int acks;
    sync_rst_n      = 1'b0;
    clk_en          = 1'b1;
    mem_enable      = 1'b0;
    mem_input_ready = 1'b1;
    drive(2'd0, 15'h0000, 2'b00, 2'd0, 16'h0000, 4'd0);

    // Reset state
    tick();
    tick();
    sync_rst_n = 1'b1;
    check_eq("rst_ack", 32'(mem_read_ack), 32'd0);
    check_eq("rst_data", 32'(mem_data_in), 32'h0);
    check_eq("rst_tag", 32'(mem_wb_dest_in), 32'h0);
    check_eq("rst_avail", 32'(mem_available), 32'd1);
    check_eq("rst_idle", 32'(mem_idle), 32'd1);

    // Word write then read: ack exactly two edges after read acceptance
    issue(2'd1, 15'h0010, 2'b11, 2'd0, 16'hBEEF, 4'd0);
    issue(2'd0, 15'h0010, 2'b11, 2'd0, 16'h0000, 4'd5);
    check_eq("lat_n1_ack", 32'(mem_read_ack), 32'd0);
    tick();
    check_eq("lat_n2_ack", 32'(mem_read_ack), 32'd1);
    check_eq("lat_data", 32'(mem_data_in), 32'hBEEF);
    check_eq("lat_tag", 32'(mem_wb_dest_in), 32'd5);
    tick();
    check_eq("lat_consumed", 32'(mem_read_ack), 32'd0);

    // Byte reads and masked writes
    issue(2'd1, 15'h0020, 2'b01, 2'd0, 16'h0080, 4'd0);
    read_expect("sb_lo", 15'h0020, 2'b01, 2'd1, 4'd1, 16'hFF80);
    read_expect("ub_lo", 15'h0020, 2'b01, 2'd2, 4'd2, 16'h0080);
    issue(2'd1, 15'h0030, 2'b11, 2'd0, 16'h7F00, 4'd0);
    read_expect("sb_hi", 15'h0030, 2'b10, 2'd1, 4'd3, 16'h007F);
    read_expect("ub_both", 15'h0030, 2'b11, 2'd2, 4'd4, 16'h007F);
    read_expect("w3_mask", 15'h0030, 2'b01, 2'd3, 4'd6, 16'h7F00);
    issue(2'd1, 15'h0010, 2'b01, 2'd0, 16'h1234, 4'd0);
    read_expect("part_wr", 15'h0010, 2'b11, 2'd0, 4'd7, 16'hBE34);
    issue(2'd1, 15'h0010, 2'b00, 2'd0, 16'hFFFF, 4'd0);
    read_expect("mask0_wr", 15'h0010, 2'b11, 2'd0, 4'd8, 16'hBE34);

    // Address aliasing above ADDR_W
    issue(2'd1, 15'h1010, 2'b11, 2'd0, 16'hA5A5, 4'd0);
    read_expect("alias", 15'h0010, 2'b11, 2'd0, 4'd9, 16'hA5A5);

    // clk_en low freezes execution and response release
    issue(2'd0, 15'h0010, 2'b11, 2'd0, 16'h0000, 4'd10);
    clk_en = 1'b0;
    tick();
    tick();
    tick();
    check_eq("cke_noexec_ack", 32'(mem_read_ack), 32'd0);
    check_eq("cke_busy", 32'(mem_idle), 32'd0);
    clk_en = 1'b1;
    wait_ack("cke");
    check_eq("cke_data", 32'(mem_data_in), 32'hA5A5);
    clk_en = 1'b0;
    tick();
    tick();
    check_eq("cke_hold_ack", 32'(mem_read_ack), 32'd1);
    check_eq("cke_hold_tag", 32'(mem_wb_dest_in), 32'd10);
    clk_en = 1'b1;
    tick();
    check_eq("cke_release", 32'(mem_read_ack), 32'd0);

    // Backpressure: slot + QDEPTH entries before mem_available drops
    for (int i = 0; i < QDEPTH + 2; i++) begin
      issue(2'd1, 15'(15'h0040 + i), 2'b11, 2'd0, 16'(16'h1000 + i), 4'd0);
    end
    mem_input_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < QDEPTH + 4; c++) begin
      drive(2'd0, 15'(15'h0040 + acc), 2'b11, 2'd0, 16'h0000, 4'(acc));
      mem_enable = 1'b1;
      if (mem_available) acc++;
      tick();
    end
    mem_enable = 1'b0;
    check_eq("full_accepts", 32'(acc), 32'(QDEPTH + 1));
    check_eq("full_avail", 32'(mem_available), 32'd0);
    mem_input_ready = 1'b1;
    for (int k = 0; k < QDEPTH + 1; k++) begin
      wait_ack($sformatf("drain%0d", k));
      check_eq($sformatf("drain%0d_tag", k), 32'(mem_wb_dest_in), 32'(k));
      check_eq($sformatf("drain%0d_data", k), 32'(mem_data_in), 32'(16'h1000 + k));
      tick();
    end
    check_eq("drain_idle", 32'(mem_idle), 32'd1);

    // Fence blocks acceptance until the pending load result is consumed
    mem_input_ready = 1'b0;
    issue(2'd1, 15'h0050, 2'b11, 2'd0, 16'h5555, 4'd0);
    issue(2'd0, 15'h0050, 2'b11, 2'd0, 16'h0000, 4'd7);
    issue(2'd2, 15'h0000, 2'b00, 2'd0, 16'h0000, 4'd0);
    check_eq("fence_avail0", 32'(mem_available), 32'd0);
    drive(2'd1, 15'h0050, 2'b11, 2'd0, 16'hDEAD, 4'd0);
    mem_enable = 1'b1;
    tick();
    tick();
    tick();
    mem_enable = 1'b0;
    check_eq("fence_hold_avail", 32'(mem_available), 32'd0);
    check_eq("fence_hold_ack", 32'(mem_read_ack), 32'd1);
    check_eq("fence_rd_data", 32'(mem_data_in), 32'h5555);
    check_eq("fence_rd_tag", 32'(mem_wb_dest_in), 32'd7);
    mem_input_ready = 1'b1;
    tick();
    check_eq("fence_freed_ack", 32'(mem_read_ack), 32'd0);
    check_eq("fence_still_blk", 32'(mem_available), 32'd0);
    check_eq("fence_not_idle", 32'(mem_idle), 32'd0);
    tick();
    check_eq("fence_pop_avail", 32'(mem_available), 32'd1);
    check_eq("fence_pop_idle", 32'(mem_idle), 32'd1);
    read_expect("fence_blocked_wr", 15'h0050, 2'b11, 2'd0, 4'd11, 16'h5555);

    // Reset mid-operation discards work, keeps RAM
    mem_input_ready = 1'b0;
    issue(2'd0, 15'h0010, 2'b11, 2'd0, 16'h0000, 4'd1);
    issue(2'd0, 15'h0010, 2'b11, 2'd0, 16'h0000, 4'd2);
    issue(2'd0, 15'h0010, 2'b11, 2'd0, 16'h0000, 4'd3);
    check_eq("pre_rst_busy", 32'(mem_idle), 32'd0);
    sync_rst_n = 1'b0;
    tick();
    sync_rst_n = 1'b1;
    check_eq("mid_rst_ack", 32'(mem_read_ack), 32'd0);
    check_eq("mid_rst_idle", 32'(mem_idle), 32'd1);
    check_eq("mid_rst_avail", 32'(mem_available), 32'd1);
    check_eq("mid_rst_data", 32'(mem_data_in), 32'h0);
    mem_input_ready = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_read_ack) acks++;
    end
    check_eq("mid_rst_no_acks", 32'(acks), 32'd0);
    read_expect("ram_kept_10", 15'h0010, 2'b11, 2'd0, 4'd12, 16'hA5A5);
    read_expect("ram_kept_50", 15'h0050, 2'b11, 2'd0, 4'd13, 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
